// File: rtl/fft_pkg.sv
// Shared constants, serializer state encoding and bin saturation for the FFT output path.
package fft_pkg;

    localparam int FFT_N_BINS = 8;
    localparam int FFT_BIN_W  = 9;
    localparam int FFT_OUT_W  = 8;

    localparam logic [7:0] FFT_SER_HEADER = 8'hA5;

    typedef enum logic {
        SER_IDLE,
        SER_SEND
    } ser_state_e;

    // Clamp an unsigned magnitude to the output beat width.
    function automatic logic [FFT_OUT_W-1:0] sat_bin(input logic [FFT_BIN_W-1:0] x);
        if (x >= FFT_BIN_W'(2 ** FFT_OUT_W)) begin
            return '1;
        end
        return x[FFT_OUT_W-1:0];
    endfunction

endpackage

// File: rtl/fft_bin_serializer_if.sv
// Frame-load and beat-output handshake bundle of the FFT bin serializer.
interface fft_bin_serializer_if
    import fft_pkg::*;
#(
    parameter int N_BINS = FFT_N_BINS,
    parameter int BIN_W  = FFT_BIN_W,
    parameter int OUT_W  = FFT_OUT_W
);

    logic                    load_valid;
    logic                    load_ready;
    logic [N_BINS*BIN_W-1:0] bins_flat;
    logic [OUT_W-1:0]        out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_first;
    logic                    out_last;

    // The serializer is the slave of the frame producer and drives the beat stream.
    modport slave (
        input  load_valid, bins_flat, out_ready,
        output load_ready, out_data, out_valid, out_first, out_last
    );

    modport master (
        output load_valid, bins_flat, out_ready,
        input  load_ready, out_data, out_valid, out_first, out_last
    );

endinterface

// File: rtl/fft_bin_sat.sv
// Combinational BIN_W -> OUT_W unsigned saturator for one FFT magnitude bin.
module fft_bin_sat
    import fft_pkg::*;
#(
    parameter int BIN_W = FFT_BIN_W,
    parameter int OUT_W = FFT_OUT_W
) (
    input  logic [BIN_W-1:0] bin_i,
    output logic [OUT_W-1:0] sat_o
);

    generate
        if (BIN_W == FFT_BIN_W && OUT_W == FFT_OUT_W) begin : g_pkg
            assign sat_o = sat_bin(bin_i);
        end else if (BIN_W > OUT_W) begin : g_clip
            assign sat_o = (|bin_i[BIN_W-1:OUT_W]) ? '1 : bin_i[OUT_W-1:0];
        end else begin : g_pass
            assign sat_o = OUT_W'(bin_i);
        end
    endgenerate

endmodule

// File: rtl/fft_bin_serializer.sv
// Captures a frame of FFT magnitude bins and streams them one saturated beat per handshake.
// Optional build macro FFT_SER_HEADER_EN prefixes every frame with an 8'hA5 header beat.
module fft_bin_serializer
    import fft_pkg::*;
#(
    parameter int N_BINS = FFT_N_BINS,
    parameter int BIN_W  = FFT_BIN_W,
    parameter int OUT_W  = FFT_OUT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    fft_bin_serializer_if.slave  bus,
    output logic                 busy
);

`ifdef FFT_SER_HEADER_EN
    localparam bit HDR_EN = 1'b1;
`else
    localparam bit HDR_EN = 1'b0;
`endif

    localparam int LAST_BEAT = HDR_EN ? N_BINS : N_BINS - 1;
    localparam int IDX_W     = $clog2(LAST_BEAT + 1);
    localparam int SEL_W     = $clog2(N_BINS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LAST_BEAT);

    ser_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [BIN_W-1:0] buf_q [N_BINS];
    logic [BIN_W-1:0] buf_d [N_BINS];
    logic [OUT_W-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             first_q, first_d;
    logic             last_q, last_d;
    logic             busy_q, busy_d;

    logic             frame_end;
    logic             load_fire;
    logic             beat_fire;
    logic [IDX_W-1:0] idx_next;
    logic [SEL_W-1:0] bin_sel;
    logic [BIN_W-1:0] bin_mux;
    logic [OUT_W-1:0] bin_sat;

    assign idx_next  = idx_q + IDX_W'(1);
    assign frame_end = (state_q == SER_SEND) && (idx_q == IDX_LAST);

    // Ready in SEND only while the final beat is being taken, so frames can abut.
    assign bus.load_ready = (state_q == SER_IDLE) || (frame_end && bus.out_ready);
    assign load_fire      = bus.load_valid && bus.load_ready;
    assign beat_fire      = valid_q && bus.out_ready;

    // With a header, beat n carries bin n-1, so the next beat reads bin idx_q.
    assign bin_sel = HDR_EN ? idx_q[SEL_W-1:0] : idx_next[SEL_W-1:0];
    assign bin_mux = load_fire ? bus.bins_flat[BIN_W-1:0] : buf_q[bin_sel];

    fft_bin_sat #(
        .BIN_W (BIN_W),
        .OUT_W (OUT_W)
    ) u_sat (
        .bin_i (bin_mux),
        .sat_o (bin_sat)
    );

    always_comb begin
        // NOTE: every variable gets its hold value first so no path can infer a latch.
        state_d = state_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        data_d  = data_q;
        valid_d = valid_q;
        first_d = first_q;
        last_d  = last_q;

        if (load_fire) begin
            state_d = SER_SEND;
            idx_d   = '0;
            for (int k = 0; k < N_BINS; k++) begin
                buf_d[k] = bus.bins_flat[k*BIN_W +: BIN_W];
            end
            data_d  = HDR_EN ? OUT_W'(FFT_SER_HEADER) : bin_sat;
            valid_d = 1'b1;
            first_d = 1'b1;
            last_d  = 1'b0;
        end else if (beat_fire && frame_end) begin
            state_d = SER_IDLE;
            idx_d   = '0;
            data_d  = '0;
            valid_d = 1'b0;
            first_d = 1'b0;
            last_d  = 1'b0;
        end else if (beat_fire) begin
            idx_d   = idx_next;
            data_d  = bin_sat;
            first_d = 1'b0;
            last_d  = (idx_next == IDX_LAST);
        end

        busy_d = (state_d == SER_SEND);
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (rst) begin
            state_q <= SER_IDLE;
            idx_q   <= '0;
            // NOTE: the frame buffer is small and cleared on reset so no stale bin is ever visible.
            for (int k = 0; k < N_BINS; k++) begin
                buf_q[k] <= '0;
            end
            data_q  <= '0;
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            first_q <= first_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.out_data  = data_q;
    assign bus.out_valid = valid_q;
    assign bus.out_first = first_q;
    assign bus.out_last  = last_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_fft_bin_serializer.sv
// Directed bench for fft_bin_serializer; expected beats are hand-computed constants.
module tb_fft_bin_serializer;
    import fft_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;

    int n_checks = 0;
    int n_fail   = 0;

    fft_bin_serializer_if bus_if ();

    fft_bin_serializer dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus_if),
        .busy (busy)
    );

    always #5 clk = ~clk;

    logic [8:0] frame_a [8] = '{9'h003, 9'h010, 9'h0FF, 9'h100, 9'h1FF, 9'h000, 9'h07F, 9'h080};
    logic [7:0] beats_a [8] = '{8'h03, 8'h10, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h7F, 8'h80};
    logic [8:0] frame_b [8] = '{9'h0AA, 9'h155, 9'h001, 9'h0FE, 9'h180, 9'h07E, 9'h011, 9'h0C3};
    logic [7:0] beats_b [8] = '{8'hAA, 8'hFF, 8'h01, 8'hFE, 8'hFF, 8'h7E, 8'h11, 8'hC3};
    logic [8:0] frame_c [8] = '{9'h001, 9'h001, 9'h001, 9'h001, 9'h001, 9'h001, 9'h001, 9'h001};
    logic [7:0] beats_c [8] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};

    logic [7:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [71:0] pack(input logic [8:0] b [8]);
        logic [71:0] p;
        for (int k = 0; k < 8; k++) p[k*9 +: 9] = b[k];
        return p;
    endfunction

    task automatic build_exp(input logic [7:0] beats [8]);
        exp_q.delete();
`ifdef FFT_SER_HEADER_EN
        exp_q.push_back(8'hA5);
`endif
        for (int k = 0; k < 8; k++) exp_q.push_back(beats[k]);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, bus_if.out_valid, 0);
        check({tag, "_first"}, bus_if.out_first, 0);
        check({tag, "_last"},  bus_if.out_last, 0);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_ready"}, bus_if.load_ready, 1);
    endtask

    // Called at a negedge; presents the frame and returns at the negedge after acceptance.
    task automatic load_frame(input logic [8:0] b [8]);
        bus_if.bins_flat  = pack(b);
        bus_if.load_valid = 1'b1;
        check("load_ready_idle", bus_if.load_ready, 1);
        @(posedge clk);
        @(negedge clk);
        bus_if.load_valid = 1'b0;
    endtask

    // Consumes exp_q with out_ready following pat, checking every presented beat.
    task automatic drain(input string tag, input logic [3:0] pat, input bit full_rate);
        int beat = 0;
        int cyc  = 0;
        int n    = exp_q.size();
        while (beat < n && cyc < 200) begin
            bus_if.out_ready = pat[cyc % 4];
            check({tag, "_valid"}, bus_if.out_valid, 1);
            check({tag, "_busy"},  busy, 1);
            check({tag, "_data"},  bus_if.out_data, exp_q[beat]);
            check({tag, "_first"}, bus_if.out_first, (beat == 0));
            check({tag, "_last"},  bus_if.out_last, (beat == n - 1));
            if (bus_if.out_ready) beat++;
            cyc++;
            @(posedge clk);
            @(negedge clk);
        end
        check({tag, "_beats"}, beat, n);
        if (full_rate) check({tag, "_cycles"}, cyc, n);
        bus_if.out_ready = 1'b1;
        check_idle({tag, "_end"});
    endtask

    initial begin
        bus_if.load_valid = 1'b0;
        bus_if.bins_flat  = '0;
        bus_if.out_ready  = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_data", bus_if.out_data, 0);
        check_idle("rst");

        // Full-rate frame with saturation corner values.
        load_frame(frame_a);
        build_exp(beats_a);
        drain("full", 4'b1111, 1'b1);

        // Same frame under back-pressure.
        load_frame(frame_a);
        build_exp(beats_a);
        drain("stall", 4'b1001, 1'b0);

        // Second frame waits on load_valid and is taken with the last beat.
        load_frame(frame_a);
        build_exp(beats_a);
        bus_if.bins_flat  = pack(frame_b);
        bus_if.load_valid = 1'b1;
        bus_if.out_ready  = 1'b1;
        for (int i = 0; i < exp_q.size(); i++) begin
            check("b2b_data", bus_if.out_data, exp_q[i]);
            check("b2b_load_ready", bus_if.load_ready, (i == exp_q.size() - 1));
            @(posedge clk);
            @(negedge clk);
        end
        bus_if.load_valid = 1'b0;
        build_exp(beats_b);
        drain("b2b_second", 4'b1111, 1'b1);

        // Reset after four beats have been accepted.
        load_frame(frame_a);
        build_exp(beats_a);
        for (int i = 0; i < 4; i++) begin
            check("pre_rst_data", bus_if.out_data, exp_q[i]);
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_data", bus_if.out_data, 0);
        check_idle("mid_rst");
        load_frame(frame_a);
        drain("post_rst", 4'b1111, 1'b1);

        // A load offered during reset must be dropped.
        rst               = 1'b1;
        bus_if.bins_flat  = pack(frame_b);
        bus_if.load_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst               = 1'b0;
        bus_if.load_valid = 1'b0;
        check_idle("rst_load");
        @(posedge clk);
        @(negedge clk);
        check("rst_load_later_valid", bus_if.out_valid, 0);

        // Uniform small frame; nine beats with the header build.
        load_frame(frame_c);
        build_exp(beats_c);
        drain("ones", 4'b1111, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
